// File: rtl/weight_fifo_array_if.sv
// weight_fifo_array_if: host write bus, pop handshake and column outputs
// of the weight staging FIFO.
// master = host / MMU side, slave = the FIFO array.
interface weight_fifo_array_if #(
    parameter int COLS   = 4,
    parameter int DATA_W = 8
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                     push_en;
    logic [COL_W-1:0]         push_col;
    logic [DATA_W-1:0]        data_in;
    logic                     pop;
    logic                     pop_ready;
    logic [COLS*DATA_W-1:0]   col_out;
    logic [COLS*DATA_W-1:0]   col_head;

    modport master (
        output push_en, push_col, data_in, pop,
        input  pop_ready, col_out, col_head
    );

    modport slave (
        input  push_en, push_col, data_in, pop,
        output pop_ready, col_out, col_head
    );
endinterface

// File: rtl/weight_fifo_array.sv
// weight_fifo_array: COLS independent weight queues filled over one shared
// write bus and drained together by a common pop. With WEIGHT_FIFO_SKEW_EN
// defined, column c is delayed by a c-stage skew chain so weights leave as a
// diagonal wavefront. Without it, col_out is the unskewed queue head.
// Per-column full/empty/count; sticky overflow/underflow; synchronous clear.
module weight_fifo_array #(
    parameter  int COLS   = 4,
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    weight_fifo_array_if.slave     bus,
    output logic [COLS-1:0]        empty,
    output logic [COLS-1:0]        full,
    output logic [COLS*CNT_W-1:0]  count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [COL_W:0]   COLS_L   = (COL_W + 1)'(COLS);

    logic [COLS-1:0] empty_s;
    logic [COLS-1:0] full_s;
    logic [COLS-1:0] push_sel_s;
    logic            pop_ok_s;
    logic            pop_rej_s;
    logic            push_drop_s;
    logic            overflow_r;
    logic            underflow_r;

    // Decide which column (if any) takes the write and whether the pop is accepted
    always_comb begin
        push_sel_s  = '0;
        push_drop_s = 1'b0;
        pop_ok_s    = bus.pop & ~|empty_s;
        pop_rej_s   = bus.pop & |empty_s;
        if (bus.push_en && ({1'b0, bus.push_col} < COLS_L)) begin
            // a full column can still take a write when the same edge pops it
            if (!full_s[bus.push_col] || pop_ok_s) begin
                push_sel_s[bus.push_col] = 1'b1;
            end else begin
                push_drop_s = 1'b1;
            end
        end else begin
            push_drop_s = 1'b0;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [DATA_W-1:0] mem_r [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_r;
        logic [PTR_W-1:0]  rd_ptr_r;
        logic [CNT_W-1:0]  cnt_r;
        logic [CNT_W-1:0]  cnt_nxt_s;
        logic              col_empty_r;
        logic              col_full_r;
        logic [DATA_W-1:0] head_s;

        // Next occupancy: simultaneous push and pop leave the count unchanged
        always_comb begin
            case ({push_sel_s[c], pop_ok_s})
                2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
                default: cnt_nxt_s = cnt_r;
            endcase
        end

        // Queue storage, pointers, occupancy and registered empty/full flags
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < DEPTH; k++) mem_r[k] <= '0;
                wr_ptr_r    <= '0;
                rd_ptr_r    <= '0;
                cnt_r       <= '0;
                col_empty_r <= 1'b1;
                col_full_r  <= 1'b0;
            end else if (clear) begin
                for (int k = 0; k < DEPTH; k++) mem_r[k] <= '0;
                wr_ptr_r    <= '0;
                rd_ptr_r    <= '0;
                cnt_r       <= '0;
                col_empty_r <= 1'b1;
                col_full_r  <= 1'b0;
            end else begin
                if (push_sel_s[c]) begin
                    mem_r[wr_ptr_r] <= bus.data_in;
                    wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PTR_ONE;
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + PTR_ONE;
                end
                cnt_r       <= cnt_nxt_s;
                col_empty_r <= (cnt_nxt_s == '0);
                col_full_r  <= (cnt_nxt_s == CNT_FULL);
            end
        end

        assign head_s  = mem_r[rd_ptr_r];
        assign empty_s[c] = col_empty_r;
        assign full_s[c]  = col_full_r;
        assign count[c*CNT_W +: CNT_W] = cnt_r;
        assign bus.col_head[c*DATA_W +: DATA_W] = head_s;

`ifdef WEIGHT_FIFO_SKEW_EN
        if (c == 0) begin : g_direct
            assign bus.col_out[c*DATA_W +: DATA_W] = head_s;
        end else begin : g_skew
            logic [DATA_W-1:0] chain_r [1:c];

            // Skew chain: shifts the pre-pop head in on every accepted pop
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 1; k <= c; k++) chain_r[k] <= '0;
                end else if (clear) begin
                    for (int k = 1; k <= c; k++) chain_r[k] <= '0;
                end else if (pop_ok_s) begin
                    chain_r[1] <= head_s;
                    for (int k = 2; k <= c; k++) chain_r[k] <= chain_r[k-1];
                end
            end

            assign bus.col_out[c*DATA_W +: DATA_W] = chain_r[c];
        end
`else
        assign bus.col_out[c*DATA_W +: DATA_W] = head_s;
`endif
    end

    // Sticky error flags, cleared only by clear or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | push_drop_s;
            underflow_r <= underflow_r | pop_rej_s;
        end
    end

    assign bus.pop_ready = ~|empty_s;
    assign empty         = empty_s;
    assign full          = full_s;
    assign overflow      = overflow_r;
    assign underflow     = underflow_r;
endmodule

// File: doc/weight_fifo_array.md
# weight_fifo_array

Parametrised multi-column weight staging FIFO between the narrow host weight bus and the systolic MMU weight-load port. One shared write bus fills COLS independent queues, selected by column index; one pop drains all columns together. Column c is presented through a c-stage skew chain so weights enter the array as a diagonal wavefront. Adds per-column full/empty/occupancy, sticky overflow/underflow flags and synchronous flush.

## Interface
- COLS, 4, number of columns / queues (≥1)
- DEPTH, 4, entries per queue (≥2, any value)
- DATA_W, 8, weight width in bits
- clk  in  1  sole clock, rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- clear  in  1  synchronous flush, priority over push/pop
- push_en  in  1  write data_in into queue push_col
- push_col  in  $clog2(COLS) (min 1)  target column; values ≥COLS ignored (no write, no flag)
- data_in  in  DATA_W  shared write bus
- pop  in  1  advance all queues by one entry
- pop_ready  out  1  ~|empty; pop is accepted only when 1
- col_out  out  COLS*DATA_W  skewed outputs, column c at bits [c*DATA_W +: DATA_W]
- col_head  out  COLS*DATA_W  unskewed head of every queue (debug)
- empty  out  COLS  per-column empty
- full  out  COLS  per-column full
- count  out  COLS*$clog2(DEPTH+1)  per-column occupancy, packed like col_out
- overflow  out  1  sticky: push to full column dropped
- underflow  out  1  sticky: pop while pop_ready=0

## Operation
- Each column: storage[DEPTH], wr_ptr, rd_ptr, count. Pointers wrap DEPTH-1 → 0 explicitly.
- Push accepted when push_col < COLS and (count < DEPTH, or count == DEPTH and a pop is accepted that cycle). Otherwise the push is dropped and overflow is set, except for out-of-range push_col.
- Pop accepted iff pop && pop_ready. All rd_ptrs advance together. Rejected pop: no state change, underflow set.
- Push and pop on the same column in one cycle: count unchanged, both pointers advance.
- col_head[c] = storage[c][rd_ptr[c]], combinational.
- Skew: column 0 col_out = col_head[0]. Column c>0 has chain s[c][1..c]. On accepted pop: s[c][1] ← col_head[c], s[c][k] ← s[c][k-1]. The chain holds when there is no pop. col_out[c] = s[c][c]. Column c therefore shows the head from c pops earlier.
- clear: pointers, counts, skew registers, and storage are set to 0. Sticky flags are cleared. Push and pop are ignored that cycle.
- reset_n low, asynchronous: same state as clear. Outputs after reset: col_out=0, col_head=0, count=0, empty=all 1, full=0, pop_ready=0, overflow=0, underflow=0. Reset asserted mid-operation discards all contents immediately.

## Timing
- Push at edge N: the entry is visible on col_head at N if the queue was empty. empty, full and count update at N.
- Pop at edge N: col_head shows the next entry after N. Column c skew output reflects the pre-pop head of pop N after c-1 further pops.
- Flags are registered from state, with no combinational path from push_en or pop to any output except through state.
- pop_ready is combinational from registered empty.

## Configuration
- WEIGHT_FIFO_SKEW_EN defined: skew chains present as above.
- Undefined: no skew registers. col_out[c] = col_head[c] for all c, and zero-latency wavefront generation is left to the MMU.

## Test plan
- Reset, COLS=4 DEPTH=4 DATA_W=8 -> col_out=0, empty=4'hF, full=0, count=0, pop_ready=0, flags 0.
- Push 0x10·(c+1)+k into column c for k=0..3 -> full=4'hF, count=4 each. Extra push 0xAA to col 2 -> dropped, overflow=1, col 2 count stays 4.
- From full, pop ×4 (WEIGHT_FIFO_SKEW_EN) -> after pop 1: col_out = {0x40?→0,0,0x20,0x11}, i.e. col0=0x11 and col1=0x20. After pop 3: col3=0x40, col2=0x31, col1=0x22, col0=0x13.
- Col 1 empty, others non-empty, pop -> no pointer or count change, underflow=1, col_out unchanged.
- Col 0 full, push col 0 plus accepted pop in the same cycle -> count stays 4, wr_ptr wraps 3→0, no overflow.
- Mid-stream: clear pulse, then separately reset_n low mid-cycle -> all counts 0, col_out=0, flags cleared immediately (reset) or at the next edge (clear).
